// File: rtl/bcd_to_bin.sv
// ---------------------------------------------------------------------------
// bcd_to_bin
//   Converts a four-digit packed BCD number (thousands..units) to binary with
//   a sequential reverse double-dabble: one shift per clock for OUT_W clocks.
//   Digits are captured on the accepting edge only. Any digit above 9 skips
//   the shifting entirely and reports err with a zero result.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous, active-low reset
//   start  in   conversion request, honoured only while idle
//   milh   in   [3:0] thousands digit
//   cent   in   [3:0] hundreds digit
//   dec    in   [3:0] tens digit
//   un     in   [3:0] units digit
//   bin    out  [OUT_W-1:0] result, held until the next completion
//   busy   out  conversion in progress
//   done   out  one-cycle completion pulse (bin/err valid)
//   err    out  last conversion had an out-of-range digit
// ---------------------------------------------------------------------------
module bcd_to_bin #(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       milh,
    input  logic [3:0]       cent,
    input  logic [3:0]       dec,
    input  logic [3:0]       un,
    output logic [OUT_W-1:0] bin,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(OUT_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [15:0]        r_bcd;
    logic [OUT_W-1:0]   r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_bad;
    logic [OUT_W-1:0]   r_bin;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_in_bad;
    logic [OUT_W+15:0]  w_shift_cat;
    logic [15:0]        w_bcd_sh;
    logic [OUT_W-1:0]   w_sr_sh;
    logic [15:0]        w_bcd_adj;

    assign w_in_bad = (milh > 4'd9) || (cent > 4'd9) || (dec > 4'd9) || (un > 4'd9);

    // The BCD register and result register shift as one word, so the BCD LSB
    // drops into the result MSB.
    assign w_shift_cat = {r_bcd, r_sr} >> 1;
    assign w_bcd_sh    = w_shift_cat[OUT_W+15:OUT_W];
    assign w_sr_sh     = w_shift_cat[OUT_W-1:0];

    // Undo the decimal carry: a nibble that reached 8+ after the halving held
    // a borrowed 10 (5 after halving) that must become a binary 8, i.e. -3.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nibble_adj
            assign w_bcd_adj[4*gi +: 4] = (w_bcd_sh[4*gi +: 4] >= 4'd8)
                                        ? (w_bcd_sh[4*gi +: 4] - 4'd3)
                                        : w_bcd_sh[4*gi +: 4];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = SHIFT;
            SHIFT:   if (r_bad || (r_cnt == LAST_CNT)) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_bcd   <= '0;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
            r_bin   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bcd  <= {milh, cent, dec, un};
                        r_sr   <= '0;
                        r_cnt  <= '0;
                        r_bad  <= w_in_bad;
                        r_busy <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (r_bad) begin
                        // Bad digit: leave immediately, busy lasts one cycle.
                        r_busy <= 1'b0;
                    end else begin
                        r_bcd <= w_bcd_adj;
                        r_sr  <= w_sr_sh;
                        if (r_cnt != LAST_CNT) begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_bin  <= r_bad ? '0 : r_sr;
                    r_err  <= r_bad;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bin  = r_bin;
    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_bcd_to_bin.sv
// ---------------------------------------------------------------------------
// tb_bcd_to_bin
//   Directed self-checking bench for bcd_to_bin (OUT_W = 16). A vector table
//   drives single conversions and checks latency, busy length, result and err;
//   hand-written sequences cover restart during SHIFT, reset mid-conversion
//   and a continuously held start.
// ---------------------------------------------------------------------------
module tb_bcd_to_bin;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  milh, cent, dec, un;
    logic [15:0] bin;
    logic        busy, done, err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bcd_to_bin #(.OUT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .milh  (milh),
        .cent  (cent),
        .dec   (dec),
        .un    (un),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    typedef struct {
        logic [3:0]  m, c, d, u;
        logic [15:0] eb;
        logic        ee;
        int          lat;
        int          bsy;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One conversion: start pulsed for one cycle; latency counted in rising
    // edges after the accepting edge, observed on falling edges.
    task automatic run_conv(input string tag, input logic [3:0] m, input logic [3:0] c,
                            input logic [3:0] d, input logic [3:0] u,
                            input logic [15:0] eb, input logic ee,
                            input int elat, input int ebusy);
        int n, busy_cnt, done_at, overlap;
        @(negedge clk);
        milh = m; cent = c; dec = d; un = u; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; done_at = -1; overlap = 0;
        busy_cnt = busy ? 1 : 0;
        while (done_at < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (busy && done) overlap++;
            if (done) done_at = n;
            else if (busy) busy_cnt++;
        end
        chk({tag, " latency"},    32'(done_at),  32'(elat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(ebusy));
        chk({tag, " bin"},        32'(bin),      32'(eb));
        chk({tag, " err"},        32'(err),      32'(ee));
        chk({tag, " overlap"},    32'(overlap),  32'd0);
        @(negedge clk);
        chk({tag, " pulse_width"}, 32'(done),    32'd0);
        $display("%s: digits %0h%0h%0h%0h -> bin=%0h err=%0b latency=%0d busy=%0d",
                 tag, m, c, d, u, bin, err, done_at, busy_cnt);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout, got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int dcnt, n, ov;
        int exp_pos[3];

        vecs[0] = '{m:4'd2, c:4'd5, d:4'd7, u:4'd8, eb:16'h0A12, ee:1'b0, lat:17, bsy:17};
        vecs[1] = '{m:4'd9, c:4'd9, d:4'd9, u:4'd9, eb:16'h270F, ee:1'b0, lat:17, bsy:17};
        vecs[2] = '{m:4'd0, c:4'd0, d:4'd0, u:4'd0, eb:16'h0000, ee:1'b0, lat:17, bsy:17};
        vecs[3] = '{m:4'd1, c:4'd2, d:4'd3, u:4'd4, eb:16'h04D2, ee:1'b0, lat:17, bsy:17};
        vecs[4] = '{m:4'hA, c:4'd0, d:4'd0, u:4'd0, eb:16'h0000, ee:1'b1, lat:2,  bsy:1};
        vecs[5] = '{m:4'd0, c:4'd0, d:4'd0, u:4'hF, eb:16'h0000, ee:1'b1, lat:2,  bsy:1};
        vecs[6] = '{m:4'd5, c:4'd0, d:4'd0, u:4'd1, eb:16'h1389, ee:1'b0, lat:17, bsy:17};
        vecs[7] = '{m:4'd0, c:4'd9, d:4'd0, u:4'd9, eb:16'h038D, ee:1'b0, lat:17, bsy:17};

        reset = 1'b0; start = 1'b0;
        milh = 4'd0; cent = 4'd0; dec = 4'd0; un = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset bin",  32'(bin),  32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset err",  32'(err),  32'd0);
        $display("reset: bin=%0h busy=%0b done=%0b err=%0b", bin, busy, done, err);
        reset = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].m, vecs[i].c, vecs[i].d, vecs[i].u,
                     vecs[i].eb, vecs[i].ee, vecs[i].lat, vecs[i].bsy);
        end

        // Result holds while idle.
        repeat (10) @(negedge clk);
        chk("hold bin", 32'(bin), 32'h038D);
        chk("hold err", 32'(err), 32'd0);
        $display("hold: bin=%0h err=%0b after 10 idle cycles", bin, err);

        // Digits changed and start re-pulsed during SHIFT.
        @(negedge clk);
        milh = 4'd2; cent = 4'd5; dec = 4'd7; un = 4'd8; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcnt = 0; n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 3) begin
                milh = 4'd9; cent = 4'd9; dec = 4'd9; un = 4'd9; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcnt++;
                n = k;
                chk("restart bin", 32'(bin), 32'h0A12);
            end
        end
        chk("restart done_count", 32'(dcnt), 32'd1);
        chk("restart latency",    32'(n),    32'd17);
        $display("restart: done_count=%0d at edge %0d bin=%0h", dcnt, n, bin);

        // Reset asserted during SHIFT iteration 8 aborts with no done.
        @(negedge clk);
        milh = 4'd0; cent = 4'd9; dec = 4'd8; un = 4'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort bin",  32'(bin),  32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort err",  32'(err),  32'd0);
        dcnt = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        chk("abort quiet", 32'(dcnt), 32'd0);
        $display("abort: bin=%0h busy=%0b done=%0b err=%0b", bin, busy, done, err);
        reset = 1'b1;
        run_conv("post_reset", 4'd0, 4'd0, 4'd4, 4'd2, 16'd42, 1'b0, 17, 17);

        // start held high: restart every 18 cycles.
        exp_pos[0] = 17; exp_pos[1] = 35; exp_pos[2] = 53;
        @(negedge clk);
        milh = 4'd1; cent = 4'd2; dec = 4'd3; un = 4'd4; start = 1'b1;
        dcnt = 0; ov = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (busy && done) ov++;
            if (done) begin
                if (dcnt < 3) chk($sformatf("held done%0d edge", dcnt), 32'(k), 32'(exp_pos[dcnt]));
                chk($sformatf("held done%0d bin", dcnt), 32'(bin), 32'd1234);
                $display("held: done at edge %0d bin=%0d", k, bin);
                dcnt++;
            end
            if (k == 39) start = 1'b0;
        end
        chk("held done_count", 32'(dcnt), 32'd3);
        chk("held overlap",    32'(ov),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
